// File: rtl/mem_write_buffer.sv
// Posted write-back buffer between the cache memory port and main memory.
// Coalesces queued writes, serves reads from the queue, drains in background.
module mem_write_buffer #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_BITS  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_req,
  input  logic                    mem_rw,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [BLOCK_BITS-1:0]   mem_wdata,
  output logic                    mem_ready,
  output logic                    mem_resp,
  output logic [BLOCK_BITS-1:0]   mem_rdata,
  output logic                    mm_req,
  output logic                    mm_rw,
  output logic [ADDR_WIDTH-1:0]   mm_addr,
  output logic [BLOCK_BITS-1:0]   mm_wdata,
  input  logic                    mm_ready,
  input  logic                    mm_resp,
  input  logic [BLOCK_BITS-1:0]   mm_rdata,
  output logic [$clog2(DEPTH):0]  wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [BLOCK_BITS-1:0] ent_data [DEPTH];

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic          hit;
  logic          co;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] co_idx;
  logic [PW-1:0] idx;

  logic accept;
  logic acc_wr;
  logic acc_rd;
  logic rd_miss;
  logic push;
  logic pop;

  assign wb_count  = count;
  assign mem_ready = (count < CW'(DEPTH)) && !rd_pend && !mem_resp;

  assign accept  = mem_req && mem_ready;
  assign acc_wr  = accept && mem_rw;
  assign acc_rd  = accept && !mem_rw;
  assign rd_miss = acc_rd && !hit;
  assign push    = acc_wr && !co;
  assign pop     = (state == WR_WAIT) && mm_resp;

  // Scan oldest to youngest so the last match wins; the head never coalesces.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    co      = 1'b0;
    co_idx  = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count &&
          ent_addr[idx][ADDR_WIDTH-1:OFFSET_BITS] ==
          mem_addr[ADDR_WIDTH-1:OFFSET_BITS]) begin
        hit     = 1'b1;
        hit_idx = idx;
        if (i != 0) begin
          co     = 1'b1;
          co_idx = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= mem_addr;
      ent_data[tail] <= mem_wdata;
    end else if (acc_wr) begin
      ent_data[co_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      rd_addr   <= '0;
      mm_req    <= 1'b0;
      mm_rw     <= 1'b0;
      mm_addr   <= '0;
      mm_wdata  <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_resp <= 1'b0;
      if (acc_wr) begin
        mem_resp <= 1'b1;
      end
      if (acc_rd && hit) begin
        mem_resp  <= 1'b1;
        mem_rdata <= ent_data[hit_idx];
      end
      if (rd_miss) begin
        rd_pend <= 1'b1;
        rd_addr <= mem_addr;
      end
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (rd_pend || rd_miss) begin
            state   <= RD_REQ;
            mm_req  <= 1'b1;
            mm_rw   <= 1'b0;
            mm_addr <= rd_pend ? rd_addr : mem_addr;
          end else if (count != '0) begin
            state    <= WR_REQ;
            mm_req   <= 1'b1;
            mm_rw    <= 1'b1;
            mm_addr  <= ent_addr[head];
            mm_wdata <= ent_data[head];
          end
        end
        RD_REQ: begin
          if (mm_ready) begin
            mm_req <= 1'b0;
            state  <= RD_WAIT;
          end
        end
        WR_REQ: begin
          if (mm_ready) begin
            mm_req <= 1'b0;
            state  <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (mm_resp) begin
            mem_resp  <= 1'b1;
            mem_rdata <= mm_rdata;
            rd_pend   <= 1'b0;
            state     <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mm_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: queue-based reference model plus an
// in-bench main memory that answers requests with random latency.
module tb_mem_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int BB    = 128;
  localparam int OB    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_rw = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [BB-1:0] mem_wdata = '0;
  logic          mem_ready;
  logic          mem_resp;
  logic [BB-1:0] mem_rdata;
  logic          mm_req;
  logic          mm_rw;
  logic [AW-1:0] mm_addr;
  logic [BB-1:0] mm_wdata;
  logic          mm_ready = 1'b0;
  logic          mm_resp = 1'b0;
  logic [BB-1:0] mm_rdata = '0;
  logic [2:0]    wb_count;

  always #5 clk = ~clk;

  mem_write_buffer #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .BLOCK_BITS(BB), .OFFSET_BITS(OB)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata),
    .mm_req(mm_req), .mm_rw(mm_rw),
    .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_ready(mm_ready), .mm_resp(mm_resp),
    .mm_rdata(mm_rdata), .wb_count(wb_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [BB-1:0] data;
  } ent_t;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [BB-1:0] data;
    int            exp_cnt;
    logic [BB-1:0] exp_rdata;
  } vec_t;

  ent_t          q[$];
  logic [BB-1:0] mem_m [logic [AW-OB-1:0]];
  int            wr_cnt [logic [AW-OB-1:0]];

  bit            rd_pend_m;
  logic [AW-1:0] rd_addr_m;
  bit            exp_resp;
  bit            exp_isrd;
  logic [BB-1:0] exp_rdata;

  bit            busy;
  bit            bkind;
  logic [AW-1:0] baddr;
  logic [BB-1:0] bdata;
  int            lat;
  int            rdy_mode;
  int            lat_max = 3;
  bit            resp_hold;

  int n_cmp;
  int n_fail;
  int t_cyc;
  int t_wr_resp;
  int t_rd_req;
  int n_rd_req;
  int n_mm_req;
  bit last_acc;
  bit pop_seen;
  bit prev_rdreq;

  function automatic logic [AW-OB-1:0] blk(logic [AW-1:0] a);
    return a[AW-1:OB];
  endfunction

  task automatic chk(string nm, logic [BB-1:0] act, logic [BB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    rd_pend_m  = 0;
    exp_resp   = 0;
    exp_isrd   = 0;
    busy       = 0;
    prev_rdreq = 0;
    mm_resp    = 0;
    mem_req    = 0;
  endtask

  // One clock: drive memory side, predict, clock, then check outputs.
  task automatic cycle();
    bit            acc, hs, rsp, pop, r_rw;
    bit            n_resp, n_isrd;
    logic [BB-1:0] n_rdata, rdv;
    logic [AW-1:0] r_addr;
    logic [BB-1:0] r_data;
    int            ci, hi;
    case (rdy_mode)
      0:       mm_ready = 1'b0;
      1:       mm_ready = 1'b1;
      default: mm_ready = 1'($urandom_range(0, 1));
    endcase
    rsp = busy && lat == 0 && !resp_hold;
    mm_resp = rsp;
    rdv = {$urandom, $urandom, $urandom, $urandom};
    if (rsp && !bkind) begin
      if (mem_m.exists(blk(baddr))) rdv = mem_m[blk(baddr)];
      else mem_m[blk(baddr)] = rdv;
    end
    mm_rdata = rdv;
    acc = mem_req && mem_ready;
    hs  = mm_req && mm_ready;
    r_rw = mm_rw;
    r_addr = mm_addr;
    r_data = mm_wdata;
    if (busy) chk("mm_req_while_busy", mm_req, 0);
    if (mm_req) begin
      n_mm_req++;
      if (mm_rw) begin
        chk("wr_req_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("wr_req_addr", mm_addr, q[0].addr);
          chk("wr_req_data", mm_wdata, q[0].data);
        end
      end else begin
        chk("rd_req_pending", rd_pend_m, 1);
        chk("rd_req_addr", mm_addr, rd_addr_m);
        if (!prev_rdreq) begin
          n_rd_req++;
          t_rd_req = t_cyc;
        end
      end
    end
    prev_rdreq = mm_req && !mm_rw;

    @(posedge clk);
    t_cyc++;
    n_resp = 0;
    n_isrd = 0;
    n_rdata = '0;
    pop = 0;
    ci = -1;
    if (rsp) begin
      if (bkind) begin
        mem_m[blk(baddr)] = bdata;
        wr_cnt[blk(baddr)] =
          wr_cnt.exists(blk(baddr)) ? wr_cnt[blk(baddr)] + 1 : 1;
        pop = 1;
        t_wr_resp = t_cyc;
      end else begin
        n_resp = 1;
        n_isrd = 1;
        n_rdata = rdv;
        rd_pend_m = 0;
      end
      busy = 0;
    end else if (busy && lat > 0) begin
      lat--;
    end
    if (hs) begin
      busy  = 1;
      bkind = r_rw;
      baddr = r_addr;
      bdata = r_data;
      lat   = $urandom_range(0, lat_max);
    end
    if (acc) begin
      if (mem_rw) begin
        for (int i = 1; i < q.size(); i++)
          if (blk(q[i].addr) == blk(mem_addr)) ci = i;
        n_resp = 1;
      end else begin
        hi = -1;
        for (int i = 0; i < q.size(); i++)
          if (blk(q[i].addr) == blk(mem_addr)) hi = i;
        if (hi >= 0) begin
          n_resp = 1;
          n_isrd = 1;
          n_rdata = q[hi].data;
        end else begin
          rd_pend_m = 1;
          rd_addr_m = mem_addr;
        end
      end
    end
    if (pop) begin
      void'(q.pop_front());
      pop_seen = 1;
    end
    if (acc && mem_rw) begin
      if (ci >= 0) q[ci - (pop ? 1 : 0)].data = mem_wdata;
      else q.push_back('{addr: mem_addr, data: mem_wdata});
    end
    exp_resp = n_resp;
    exp_isrd = n_isrd;
    exp_rdata = n_rdata;
    last_acc = acc;

    @(negedge clk);
    chk("wb_count", wb_count, q.size());
    chk("mem_resp", mem_resp, exp_resp);
    if (exp_resp && exp_isrd) chk("mem_rdata", mem_rdata, exp_rdata);
    chk("mem_ready", mem_ready,
        q.size() < DEPTH && !rd_pend_m && !exp_resp);
  endtask

  task automatic do_op(bit rw, logic [AW-1:0] a, logic [BB-1:0] d);
    int n = 0;
    mem_req = 1;
    mem_rw = rw;
    mem_addr = a;
    mem_wdata = d;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 200);
    mem_req = 0;
    chk("op_accepted", last_acc, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 300 && (q.size() != 0 || busy || rd_pend_m ||
           exp_resp || mm_req || wb_count != 0)) begin
      cycle();
      n++;
    end
    chk("idle_reached", n < 300, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_mm_req", mm_req, 0);
    chk("rst_wb_count", wb_count, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    rst = 1;
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    bit pb;
    int base;

    vecs[0] = '{1, 32'h100, 128'hA1, 1, '0};
    vecs[1] = '{1, 32'h200, 128'hB2, 2, '0};
    vecs[2] = '{1, 32'h204, 128'hC3, 2, '0};
    vecs[3] = '{1, 32'h100, 128'hE4, 3, '0};
    vecs[4] = '{0, 32'h10C, '0, 3, 128'hE4};
    vecs[5] = '{0, 32'h208, '0, 3, 128'hC3};
    vecs[6] = '{1, 32'h300, 128'hF5, 4, '0};
    vecs[7] = '{0, 32'h304, '0, 4, 128'hF5};

    do_reset();

    // Table: mm_ready held low so nothing drains.
    rdy_mode = 0;
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].rw, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d_count", i), wb_count, vecs[i].exp_cnt);
      if (!vecs[i].rw) begin
        chk($sformatf("vec%0d_resp", i), mem_resp, 1);
        chk($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      end
    end
    cycle();
    chk("full_not_ready", mem_ready, 0);
    rdy_mode = 1;
    wait_idle();
    chk("tbl_mem_100", mem_m[blk(32'h100)], 128'hE4);
    chk("tbl_mem_200", mem_m[blk(32'h200)], 128'hC3);
    chk("tbl_mem_300", mem_m[blk(32'h300)], 128'hF5);

    // Single write drains.
    do_reset();
    rdy_mode = 1;
    do_op(1, 32'h100, 128'hD1);
    chk("t1_ack", mem_resp, 1);
    chk("t1_count", wb_count, 1);
    chk("t1_no_req_yet", mm_req, 0);
    cycle();
    chk("t1_mm_req", mm_req, 1);
    chk("t1_mm_rw", mm_rw, 1);
    chk("t1_mm_addr", mm_addr, 32'h100);
    wait_idle();
    chk("t1_count_zero", wb_count, 0);

    // Full buffer stalls the fifth write until a pop.
    do_reset();
    rdy_mode = 0;
    for (int i = 1; i <= 4; i++) do_op(1, AW'(i * 256), BB'(i));
    chk("t2_count4", wb_count, 4);
    chk("t2_not_ready", mem_ready, 0);
    mem_req = 1;
    mem_rw = 1;
    mem_addr = 32'h500;
    mem_wdata = 128'h5;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_no_accept", last_acc, 0);
    end
    pop_seen = 0;
    rdy_mode = 1;
    n = 0;
    pb = 0;
    do begin
      pb = pop_seen;
      cycle();
      n++;
    end while (!last_acc && n < 100);
    mem_req = 0;
    chk("t2_accepted", last_acc, 1);
    chk("t2_after_pop", pb, 1);
    wait_idle();

    // Coalescing behind an in-flight head.
    do_reset();
    wr_cnt.delete();
    rdy_mode = 0;
    do_op(1, 32'h100, 128'hD0);
    do_op(1, 32'h200, 128'hD1);
    do_op(1, 32'h200, 128'hD2);
    chk("t3_count", wb_count, 2);
    rdy_mode = 1;
    wait_idle();
    chk("t3_mem_data", mem_m[blk(32'h200)], 128'hD2);
    chk("t3_one_write", wr_cnt[blk(32'h200)], 1);

    // Read hit from the queue.
    do_reset();
    rdy_mode = 0;
    do_op(1, 32'h300, 128'hD3);
    base = n_rd_req;
    do_op(0, 32'h300, '0);
    chk("t4_resp", mem_resp, 1);
    chk("t4_rdata", mem_rdata, 128'hD3);
    for (int i = 0; i < 3; i++) cycle();
    rdy_mode = 1;
    wait_idle();
    chk("t4_no_rd_req", n_rd_req, base);

    // Read miss with memory idle.
    do_reset();
    rdy_mode = 1;
    mem_m[blk(32'h900)] = 128'h9999;
    do_op(0, 32'h900, '0);
    chk("t5a_mm_req", mm_req, 1);
    chk("t5a_mm_rw", mm_rw, 0);
    n = 0;
    while (!mem_resp && n < 50) begin
      cycle();
      n++;
    end
    chk("t5a_resp", mem_resp, 1);
    chk("t5a_rdata", mem_rdata, 128'h9999);
    wait_idle();

    // Read miss behind an in-flight drain.
    do_reset();
    rdy_mode = 1;
    mem_m[blk(32'h700)] = 128'h7777;
    do_op(1, 32'h800, 128'h88);
    n = 0;
    while (!(busy && bkind) && n < 50) begin
      cycle();
      n++;
    end
    do_op(0, 32'h700, '0);
    n = 0;
    while (n < 50) begin
      chk("t5_ready_low", mem_ready, 0);
      if (mem_resp) break;
      cycle();
      n++;
    end
    chk("t5_resp", mem_resp, 1);
    chk("t5_rdata", mem_rdata, 128'h7777);
    chk("t5_rd_after_drain", t_rd_req, t_wr_resp + 1);
    wait_idle();

    // Reset while a drain waits for memory.
    do_reset();
    rdy_mode = 1;
    resp_hold = 1;
    do_op(1, 32'h100, 128'h1);
    do_op(1, 32'h200, 128'h2);
    do_op(1, 32'h300, 128'h3);
    n = 0;
    while (!busy && n < 50) begin
      cycle();
      n++;
    end
    chk("t6_in_wait", busy, 1);
    chk("t6_count3", wb_count, 3);
    rst = 0;
    #1;
    chk("t6_mm_req", mm_req, 0);
    chk("t6_count0", wb_count, 0);
    clear_model();
    resp_hold = 0;
    @(negedge clk);
    rst = 1;
    base = n_mm_req;
    for (int i = 0; i < 10; i++) cycle();
    chk("t6_no_drain", n_mm_req, base);
    chk("t6_ready", mem_ready, 1);

    // Random traffic against the model.
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      mem_req = 1'($urandom_range(0, 1));
      mem_rw = 1'($urandom_range(0, 1));
      mem_addr = AW'(($urandom_range(0, 5) << 8) | $urandom_range(0, 15));
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    mem_req = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
